execute_stage: RTL and testbench
================================

# execute_stage

Execute (EX) stage of the pipelined RV32 core. It consumes the forwarding selects produced for the EX operands and builds the forwarded operands. It computes single-cycle ALU results and runs an iterative radix-2 divider for DIV/DIVU/REM/REMU. During a divide it raises a stall request to the hazard logic. Its outputs feed the EX/MEM pipeline register.

## Interface
- XLEN, 32: datapath width
- DIV_CYCLES, XLEN: divider iterations; one quotient bit per cycle

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ValidE  in  1  EX holds a real instruction, not a bubble
- FlushE  in  1  kill the EX instruction and abort any divide
- ForwardAE, ForwardBE  in  2  operand select: 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM, 11 = reserved (treated as 00)
- RD1E, RD2E  in  XLEN  register-file read data latched in ID/EX
- ALUResultM  in  XLEN  MEM-stage result, forwarding source
- ResultW  in  XLEN  WB-stage result, forwarding source
- ImmExtE  in  XLEN  sign-extended immediate
- ALUSrcE  in  1  selects the immediate as SrcB
- ALUControlE  in  5  operation, of type alu_op_t
- ALUResultE  out  XLEN  result to EX/MEM
- WriteDataE  out  XLEN  forwarded B operand, used as store data
- ZeroE  out  1  ALUResultE == 0
- StallE  out  1  hold F/D/E and bubble M while high
- DivBusyE  out  1  divider FSM is not IDLE, for debug and coverage

## Operation
- SrcA is the forwarded A operand.
- SrcB is ImmExtE when ALUSrcE is 1, otherwise the forwarded B operand.
- WriteDataE always carries the forwarded B operand.
- Single-cycle ops, all combinational with StallE = 0:
  - ADD, SUB, AND, OR, XOR
  - SLT (signed), SLTU
  - SLL, SRL, SRA using SrcB[4:0]
  - PASSB
- Divide op codes: DIV, DIVU, REM, REMU.
- Divider FSM states are IDLE, RUN and DONE. Transitions:
  - IDLE→RUN when ValidE & is_div & !FlushE. The FSM captures SrcA, SrcB, the op and the operand signs into registers, because forwarding sources move while the pipeline is stalled.
  - IDLE→DONE directly for the special cases:
    - divisor 0: quotient = all ones, remainder = dividend
    - signed overflow, dividend = 0x80000000 with divisor = -1: quotient = 0x80000000, remainder = 0
  - RUN: restoring shift-subtract on magnitudes, one bit per cycle; counter runs DIV_CYCLES-1 down to 0; RUN→DONE when it reaches 0.
  - DONE: apply signs and present the result. Quotient is negated when sa^sb (DIV). Remainder takes the sign of the dividend (REM). DONE→IDLE on the next cycle unconditionally.
- StallE = (IDLE & ValidE & is_div & !FlushE) | RUN. In DONE, StallE = 0 and ALUResultE = the divider result.
- FlushE in any state sends the FSM to IDLE next cycle and forces StallE = 0 that cycle.
- Unknown ALUControlE values give ALUResultE = 0 with no stall.

## Timing
- Reset: FSM IDLE, counter 0, captured operands 0, DivBusyE 0. All outputs are combinational from the inputs plus the reset state, so with ValidE = 0 they read 0.
- ALU ops: zero latency, result valid in the issue cycle.
- Normal divide:
  - issue cycle is cycle 0
  - RUN covers cycles 1..DIV_CYCLES
  - DONE is at cycle DIV_CYCLES+1, which is cycle 33 for default parameters
  - StallE is high for DIV_CYCLES+1 cycles
- Special-case divide: StallE high for 1 cycle; DONE at cycle 1.
- Back-to-back divides: the second is issued from IDLE, one cycle after DONE, because the ID/EX register advances at DONE.
- rst_n deassertion mid-divide is not defined. Assertion of rst_n at any time returns the FSM to IDLE asynchronously.

## Structure
- Shared package riscv_pkg holds:
  - alu_op_t enum (5 bits): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASSB=10, DIV=16, DIVU=17, REM=18, REMU=19
  - fwd_sel_t enum: FWD_REG=0, FWD_WB=1, FWD_MEM=2
  - div_state_t enum
- Sub-module iter_divider contains the FSM, counter, magnitude datapath and sign fix. It has a start/flush/busy/done/result interface. execute_stage holds the operand muxes, the ALU and the result select.

## Test plan
- Forwarding select: RD1E=5, ALUResultM=7, ResultW=9, ADD with ALUSrcE=0 and RD2E=1, ForwardBE=00:
  - ForwardAE=10 → ALUResultE = 8
  - ForwardAE=01 → ALUResultE = 10
  - ForwardAE=11 → ALUResultE = 6
- Store data: ALUSrcE=1, ImmExtE=4, ForwardBE=10, ALUResultM=0x55 → WriteDataE = 0x55 and SrcB = 4.
- Signed divide: DIV -7/2 → StallE high 33 cycles; at cycle 33, ALUResultE = -3 and StallE = 0. REM with the same operands gives -1.
- Operand capture: DIVU 100/7 while ALUResultM is changed during RUN → result 14. REMU with the same operands gives 2.
- Special cases:
  - DIV x/0 → 0xFFFFFFFF at cycle 1
  - REM 0x80000000/-1 → 0 at cycle 1
  - in both cases StallE is high for exactly 1 cycle
- Abort: FlushE pulsed at cycle 10 of a divide → StallE = 0 in that cycle; a new divide 2 cycles later completes correctly. rst_n asserted mid-RUN → DivBusyE = 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types shared by the RV32 core pipeline stages: ALU op codes, forwarding
// selects and the divider state encoding.
package riscv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SLT   = 5'd5,
        ALU_SLTU  = 5'd6,
        ALU_SLL   = 5'd7,
        ALU_SRL   = 5'd8,
        ALU_SRA   = 5'd9,
        ALU_PASSB = 5'd10,
        ALU_DIV   = 5'd16,
        ALU_DIVU  = 5'd17,
        ALU_REM   = 5'd18,
        ALU_REMU  = 5'd19
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Works on operand
// magnitudes and fixes the signs in DONE; divide-by-zero and overflow skip RUN.
module iter_divider
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;

    logic            is_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            fits;

    assign is_signed = (op == ALU_DIV) || (op == ALU_REM);
    assign sa        = is_signed & dividend[XLEN-1];
    assign sb        = is_signed & divisor[XLEN-1];
    assign mag_a     = sa ? -dividend : dividend;
    assign mag_b     = sb ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign overflow  = is_signed && (dividend == INT_MIN) && (divisor == '1);

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh = {rem, quot[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvsr};
    assign fits   = ~diff[XLEN];

    // NOTE: every state register here is assigned with <= so all of them update
    // together from the same pre-edge values; the captured operands are reset
    // too, so nothing in the datapath is ever X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            quot   <= '0;
            rem    <= '0;
            dvsr   <= '0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        op_rem <= (op == ALU_REM) || (op == ALU_REMU);
                        if (div_zero) begin
                            quot  <= '1;
                            rem   <= dividend;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DIV_DONE;
                        end else if (overflow) begin
                            quot  <= INT_MIN;
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DIV_DONE;
                        end else begin
                            quot  <= mag_a;
                            rem   <= '0;
                            dvsr  <= mag_b;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            cnt   <= CW'(DIV_CYCLES - 1);
                            state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    quot <= {quot[XLEN-2:0], fits};
                    rem  <= fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                    if (cnt == '0) state <= DIV_DONE;
                    else           cnt   <= cnt - CW'(1);
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy   = (state != DIV_IDLE);
    assign done   = (state == DIV_DONE);
    assign result = op_rem ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the RV32 pipeline: operand forwarding, single-cycle ALU and the
// iterative divider, with a stall request while a divide is in flight.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidE,
    input  logic            FlushE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic            ALUSrcE,
    input  logic [4:0]      ALUControlE,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic            ZeroE,
    output logic            StallE,
    output logic            DivBusyE
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] div_result;
    logic            is_div;
    logic            div_start;
    logic            div_busy;
    logic            div_done;

    // NOTE: each always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch. Select 11 falls back to the register.
    always_comb begin
        fwd_a = RD1E;
        case (fwd_sel_t'(ForwardAE))
            FWD_WB:  fwd_a = ResultW;
            FWD_MEM: fwd_a = ALUResultM;
            default: fwd_a = RD1E;
        endcase
    end

    always_comb begin
        fwd_b = RD2E;
        case (fwd_sel_t'(ForwardBE))
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
    end

    assign srca       = fwd_a;
    assign srcb       = ALUSrcE ? ImmExtE : fwd_b;
    assign WriteDataE = fwd_b;

    always_comb begin
        alu_res = '0;
        case (alu_op_t'(ALUControlE))
            ALU_ADD:   alu_res = srca + srcb;
            ALU_SUB:   alu_res = srca - srcb;
            ALU_AND:   alu_res = srca & srcb;
            ALU_OR:    alu_res = srca | srcb;
            ALU_XOR:   alu_res = srca ^ srcb;
            ALU_SLT:   alu_res = ($signed(srca) < $signed(srcb)) ? XLEN'(1) : '0;
            ALU_SLTU:  alu_res = (srca < srcb) ? XLEN'(1) : '0;
            ALU_SLL:   alu_res = srca << srcb[4:0];
            ALU_SRL:   alu_res = srca >> srcb[4:0];
            ALU_SRA:   alu_res = $unsigned($signed(srca) >>> srcb[4:0]);
            ALU_PASSB: alu_res = srcb;
            default:   alu_res = '0;
        endcase
    end

    assign is_div    = is_div_op(ALUControlE);
    assign div_start = ValidE & is_div & ~FlushE;

    iter_divider #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .flush    (FlushE),
        .dividend (srca),
        .divisor  (srcb),
        .op       (ALUControlE),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );

    // The pipeline advances in DONE, so only issue and RUN hold it.
    assign StallE     = (~div_busy & div_start) | (div_busy & ~div_done & ~FlushE);
    assign ALUResultE = is_div ? (div_done ? div_result : '0) : alu_res;
    assign ZeroE      = (ALUResultE == '0);
    assign DivBusyE   = div_busy;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: stimulus pushes expected results into a
// scoreboard; a negedge monitor pops and compares on every retiring instruction.
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, FlushE, ALUSrcE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] RD1E, RD2E, ALUResultM, ResultW, ImmExtE;
    logic [4:0]  ALUControlE;
    logic [31:0] ALUResultE, WriteDataE;
    logic        ZeroE, StallE, DivBusyE;

    execute_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ValidE      (ValidE),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ALUResultM  (ALUResultM),
        .ResultW     (ResultW),
        .ImmExtE     (ImmExtE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .ALUResultE  (ALUResultE),
        .WriteDataE  (WriteDataE),
        .ZeroE       (ZeroE),
        .StallE      (StallE),
        .DivBusyE    (DivBusyE)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          stalls;
        logic        chk_wd;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an instruction retires when it is valid, not flushed and not stalled.
    always @(negedge clk) begin
        if (!rst_n || FlushE) begin
            stall_cnt = 0;
        end else if (ValidE) begin
            if (StallE) begin
                stall_cnt++;
            end else if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got %h expected no instruction", ALUResultE);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_res"}, ALUResultE, e.res);
                check({e.name, "_zero"}, 32'(ZeroE), 32'(e.res == 32'h0));
                check({e.name, "_stall"}, 32'(stall_cnt), 32'(e.stalls));
                if (e.chk_wd) check({e.name, "_wdata"}, WriteDataE, e.wd);
                stall_cnt = 0;
            end
        end
    end

    task automatic set_ops(input logic [4:0] op, input logic [1:0] fa, input logic [1:0] fb,
                           input logic alusrc, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [31:0] m, input logic [31:0] w);
        ALUControlE = op;  ForwardAE = fa;  ForwardBE = fb;  ALUSrcE = alusrc;
        RD1E = rd1;  RD2E = rd2;  ImmExtE = imm;  ALUResultM = m;  ResultW = w;
    endtask

    // Holds the instruction in EX until it retires; optionally disturbs the MEM
    // forwarding source or flushes at a given cycle. Entered and left at posedge+1.
    task automatic issue(input string name, input logic [31:0] res, input int stalls,
                         input logic chk_wd, input logic [31:0] wd,
                         input int perturb_at, input int flush_at);
        exp_t e;
        int   cyc = 0;
        bit   fin = 0;
        e.name = name;  e.res = res;  e.stalls = stalls;  e.chk_wd = chk_wd;  e.wd = wd;
        if (flush_at < 0) sb.push_back(e);
        ValidE = 1'b1;
        while (!fin) begin
            if (cyc == perturb_at) ALUResultM = 32'hDEAD_BEEF;
            if (cyc == flush_at) FlushE = 1'b1;
            @(negedge clk);
            if (cyc == flush_at) begin
                check({name, "_flush_stall"}, 32'(StallE), 32'h0);
                fin = 1;
            end else if (!StallE) begin
                fin = 1;
            end else if (cyc > 100) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got stall after %0d cycles expected release by 34", name, cyc);
                fin = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        ValidE = 1'b0;
        FlushE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;  ValidE = 1'b0;  FlushE = 1'b0;
        set_ops(5'd0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        check("rst_result", ALUResultE, 32'h0);
        check("rst_wdata", WriteDataE, 32'h0);
        check("rst_zero", 32'(ZeroE), 32'h1);
        check("rst_stall", 32'(StallE), 32'h0);
        check("rst_busy", 32'(DivBusyE), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding selects for the A operand.
        set_ops(ALU_ADD, 2'b10, 2'b00, 1'b0, 32'd5, 32'd1, 32'h0, 32'd7, 32'd9);
        issue("fwd_mem", 32'd8, 0, 1'b1, 32'd1, -1, -1);
        set_ops(ALU_ADD, 2'b01, 2'b00, 1'b0, 32'd5, 32'd1, 32'h0, 32'd7, 32'd9);
        issue("fwd_wb", 32'd10, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_ADD, 2'b11, 2'b00, 1'b0, 32'd5, 32'd1, 32'h0, 32'd7, 32'd9);
        issue("fwd_rsv", 32'd6, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_ADD, 2'b00, 2'b01, 1'b0, 32'd5, 32'd1, 32'h0, 32'd7, 32'd9);
        issue("fwd_b_wb", 32'd14, 0, 1'b1, 32'd9, -1, -1);

        // Store data is the forwarded B while SrcB is the immediate.
        set_ops(ALU_PASSB, 2'b00, 2'b10, 1'b1, 32'd0, 32'd1, 32'd4, 32'h55, 32'd9);
        issue("store", 32'd4, 0, 1'b1, 32'h55, -1, -1);

        // Single-cycle ALU ops.
        set_ops(ALU_SUB, 2'b00, 2'b00, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0);
        issue("sub", 32'hFFFF_FFFE, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_SUB, 2'b00, 2'b00, 1'b0, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0);
        issue("sub_zero", 32'h0, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_AND, 2'b00, 2'b00, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 32'h0, 32'h0);
        issue("and", 32'h00F0_1200, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_OR, 2'b00, 2'b00, 1'b0, 32'hF000_0001, 32'h0000_0F10, 32'h0, 32'h0, 32'h0);
        issue("or", 32'hF000_0F11, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_XOR, 2'b00, 2'b00, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 32'h0, 32'h0);
        issue("xor", 32'hF0F0_F0F0, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_SLT, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h0);
        issue("slt", 32'd1, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_SLTU, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h0);
        issue("sltu", 32'd0, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_SLL, 2'b00, 2'b00, 1'b0, 32'd1, 32'h0000_003F, 32'h0, 32'h0, 32'h0);
        issue("sll", 32'h8000_0000, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_SRL, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'd31, 32'h0, 32'h0, 32'h0);
        issue("srl", 32'd1, 0, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_SRA, 2'b00, 2'b00, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h0, 32'h0);
        issue("sra", 32'hF800_0000, 0, 1'b0, 32'h0, -1, -1);
        set_ops(5'd11, 2'b00, 2'b00, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0);
        issue("unknown", 32'h0, 0, 1'b0, 32'h0, -1, -1);

        // Signed divide and remainder, back to back.
        set_ops(ALU_DIV, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'h0);
        issue("div_m7_2", 32'hFFFF_FFFD, 33, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_REM, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'h0);
        issue("rem_m7_2", 32'hFFFF_FFFF, 33, 1'b0, 32'h0, -1, -1);

        // Forwarded dividend changes during RUN; the captured copy must be used.
        set_ops(ALU_DIVU, 2'b10, 2'b00, 1'b0, 32'd0, 32'd7, 32'h0, 32'd100, 32'h0);
        issue("divu_capture", 32'd14, 33, 1'b0, 32'h0, 3, -1);
        set_ops(ALU_REMU, 2'b10, 2'b00, 1'b0, 32'd0, 32'd7, 32'h0, 32'd100, 32'h0);
        issue("remu_capture", 32'd2, 33, 1'b0, 32'h0, 3, -1);

        // Special cases resolve without RUN.
        set_ops(ALU_DIV, 2'b00, 2'b00, 1'b0, 32'd123, 32'd0, 32'h0, 32'h0, 32'h0);
        issue("div_by0", 32'hFFFF_FFFF, 1, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_REMU, 2'b00, 2'b00, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 32'h0);
        issue("remu_by0", 32'd5, 1, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_REM, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        issue("rem_ovf", 32'h0, 1, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_DIV, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        issue("div_ovf", 32'h8000_0000, 1, 1'b0, 32'h0, -1, -1);

        // Flush at cycle 10, one bubble, then a fresh divide.
        set_ops(ALU_DIV, 2'b00, 2'b00, 1'b0, 32'd1000, 32'd3, 32'h0, 32'h0, 32'h0);
        issue("div_flushed", 32'h0, 0, 1'b0, 32'h0, -1, 10);
        check("flush_idle", 32'(DivBusyE), 32'h0);
        @(posedge clk);
        #1;
        set_ops(ALU_DIV, 2'b00, 2'b00, 1'b0, 32'd20, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'h0);
        issue("div_after_flush", 32'hFFFF_FFFA, 33, 1'b0, 32'h0, -1, -1);
        set_ops(ALU_REM, 2'b00, 2'b00, 1'b0, 32'd20, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'h0);
        issue("rem_after_flush", 32'd2, 33, 1'b0, 32'h0, -1, -1);

        // Asynchronous reset in the middle of RUN.
        set_ops(ALU_DIVU, 2'b00, 2'b00, 1'b0, 32'd50, 32'd5, 32'h0, 32'h0, 32'h0);
        ValidE = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("run_busy", 32'(DivBusyE), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_midrun_busy", 32'(DivBusyE), 32'h0);
        ValidE = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
